instr_fifo: RTL

//  Receiving end of the fetch->decode handshake. Captures each fetched {instr, pc} pair when the fetch

---
 rtl/instr_fifo_pkg.sv | 6 +
 rtl/fifo_ptr_ctrl.sv | 71 +++++++
 rtl/instr_fifo.sv | 55 +++++
 3 files changed

// File: rtl/instr_fifo_pkg.sv
// Shared defaults for the fetch->decode instruction queue.
package instr_fifo_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int IW_DEF    = 32;
  localparam int PW_DEF    = 64;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count, full/empty and flush for a circular queue.
module fifo_ptr_ctrl
  import instr_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  output logic [AW-1:0] rd_ptr_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          wr_en_o,
  output logic          overflow_err_o
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          at_cap, pop, push;

  assign at_cap = (count_q == DEPTH_C);
  assign pop    = pop_req_i & (count_q != '0);
  // A pop frees the slot in the same cycle, so a push at capacity is still legal then.
  assign push   = push_req_i & (~at_cap | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (push_req_i & at_cap & ~pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign rd_ptr_o       = rd_ptr_q;
  assign wr_ptr_o       = wr_ptr_q;
  assign count_o        = count_q;
  assign empty_o        = (count_q == '0);
  // One push may already be in flight from fetch's registered accept.
  assign full_o         = (count_q >= DEPTH_C - 1'b1);
  assign wr_en_o        = push & ~flush_i;
  assign overflow_err_o = err_q;
endmodule

// File: rtl/instr_fifo.sv
// Fetch->decode instruction queue: captures {instr, pc} pairs and presents them
// first-word-fall-through to decode.
module instr_fifo
  import instr_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 3,
  parameter int IW    = IW_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          fetch_decode_vaild,
  input  logic [IW-1:0] instr,
  input  logic [PW-1:0] pc_in,
  output logic          instrFifo_full,
  output logic          decode_vaild,
  output logic [IW-1:0] decode_instr,
  output logic [PW-1:0] decode_pc,
  input  logic          decode_ready,
  output logic [AW:0]   fifo_count,
  output logic          overflow_err
);
  logic [IW+PW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             empty, wr_en;

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
    .clk_i          (CLK),
    .rst_i          (RST),
    .flush_i        (flush),
    .push_req_i     (fetch_decode_vaild),
    .pop_req_i      (decode_ready),
    .rd_ptr_o       (rd_ptr),
    .wr_ptr_o       (wr_ptr),
    .count_o        (fifo_count),
    .empty_o        (empty),
    .full_o         (instrFifo_full),
    .wr_en_o        (wr_en),
    .overflow_err_o (overflow_err)
  );

  // Storage is cleared only by reset; flush just rewinds the pointers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= {instr, pc_in};
    end
  end

  assign decode_vaild              = ~empty;
  assign {decode_instr, decode_pc} = mem_q[rd_ptr];
endmodule
